// File: rtl/decap_pkg.sv
// Shared constants and FSM state type for the decapsulation datapath.
package decap_pkg;

    localparam int DECAP_P = 761;
    localparam int DECAP_Q = 4591;
    localparam int COEF_W  = 13;
    localparam int RES_W   = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_LATCH,
        S_KICK,
        S_WAIT,
        S_WRITE,
        S_FIN
    } sched_state_t;

endpackage

// File: rtl/decap_idx_counter.sv
// Coefficient index counter: clear, increment, and last-index flag (idx == P-1).
module decap_idx_counter
    import decap_pkg::*;
#(
    parameter int P  = DECAP_P,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [AW-1:0] idx,
    output logic          last
);

    assign last = (idx == AW'(P - 1));

    // Index register; saturates at P-1 so it can never wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx <= '0;
        end else if (clr) begin
            idx <= '0;
        end else if (inc && !last) begin
            idx <= idx + AW'(1);
        end
    end

endmodule

// File: rtl/decap_mod3_scheduler.sv
// Walks coefficients 0..P-1: read from input RAM, hand to the mod-3 datapath,
// write the 2-bit result to the output RAM.
// Optional watchdog on the datapath handshake: define DECAP_SCHED_WDT_EN.
module decap_mod3_scheduler
    import decap_pkg::*;
#(
    parameter int P          = DECAP_P,
    parameter int Q          = DECAP_Q,
    parameter int AW         = 10,
    parameter int WDT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              range_err,
    output logic              timeout,
    output logic              rd_en,
    output logic [AW-1:0]     rd_addr,
    input  logic [COEF_W-1:0] rd_data,
    output logic [COEF_W-1:0] coef_in,
    output logic              coef_start,
    input  logic              coef_done,
    input  logic [RES_W-1:0]  coef_res,
    output logic              wr_en,
    output logic [AW-1:0]     wr_addr,
    output logic [RES_W-1:0]  wr_data
);

    localparam logic [COEF_W-1:0] Q_C = COEF_W'(Q);

    sched_state_t         state;
    sched_state_t         state_nxt;
    logic [AW-1:0]        idx;
    logic                 idx_last;
    logic                 idx_clr;
    logic                 idx_inc;
    logic [RES_W-1:0]     res;
    logic                 accept;
    logic                 wdt_expired;

    decap_idx_counter #(
        .P  (P),
        .AW (AW)
    ) u_idx (
        .clk  (clk),
        .rst  (rst),
        .clr  (idx_clr),
        .inc  (idx_inc),
        .idx  (idx),
        .last (idx_last)
    );

    assign accept  = (state == S_IDLE) && start;
    assign rd_addr = idx;
    assign wr_addr = idx;
    assign wr_data = res;

`ifdef DECAP_SCHED_WDT_EN
    localparam int WCW = $clog2(WDT_CYCLES + 1);

    logic [WCW-1:0] wcnt;
    logic           timeout_r;

    assign wdt_expired = (state == S_WAIT) && !coef_done
                         && (wcnt == WCW'(WDT_CYCLES - 1));
    assign timeout     = timeout_r;

    // Counts WAIT cycles per coefficient; the sticky flag records any expiry in the pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt      <= '0;
            timeout_r <= 1'b0;
        end else begin
            if (state == S_KICK) begin
                wcnt <= '0;
            end else if (state == S_WAIT) begin
                wcnt <= wcnt + WCW'(1);
            end
            if (accept) begin
                timeout_r <= 1'b0;
            end else if (wdt_expired) begin
                timeout_r <= 1'b1;
            end
        end
    end
`else
    assign wdt_expired = 1'b0;
    assign timeout     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and strobes decoded from the current state.
    always_comb begin
        state_nxt  = state;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        rd_en      = 1'b0;
        coef_start = 1'b0;
        wr_en      = 1'b0;
        idx_clr    = 1'b0;
        idx_inc    = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    idx_clr   = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_READ: begin
                rd_en     = 1'b1;
                state_nxt = S_LATCH;
            end
            S_LATCH: state_nxt = S_KICK;
            S_KICK: begin
                coef_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (coef_done || wdt_expired) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                wr_en = 1'b1;
                if (idx_last) begin
                    state_nxt = S_FIN;
                end else begin
                    idx_inc   = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Coefficient/result capture and the sticky range flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_in   <= '0;
            res       <= '0;
            range_err <= 1'b0;
        end else begin
            if (accept) begin
                range_err <= 1'b0;
            end
            if (state == S_LATCH) begin
                coef_in <= rd_data;
                if (rd_data >= Q_C) begin
                    range_err <= 1'b1;
                end
            end
            if (state == S_WAIT) begin
                if (coef_done) begin
                    res <= coef_res;
                end else if (wdt_expired) begin
                    res <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_decap_mod3_scheduler.sv
// Self-checking bench for decap_mod3_scheduler (P=4, WDT_CYCLES=8).
module tb_decap_mod3_scheduler;
    import decap_pkg::*;

    localparam int TP   = 4;
    localparam int TQ   = 4591;
    localparam int TAW  = 3;
    localparam int TWDT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              range_err;
    logic              timeout;
    logic              rd_en;
    logic [TAW-1:0]    rd_addr;
    logic [COEF_W-1:0] rd_data;
    logic [COEF_W-1:0] coef_in;
    logic              coef_start;
    logic              coef_done;
    logic              coef_done_m;
    logic              spur;
    logic [RES_W-1:0]  coef_res;
    logic              wr_en;
    logic [TAW-1:0]    wr_addr;
    logic [RES_W-1:0]  wr_data;

    assign coef_done = coef_done_m | spur;

    decap_mod3_scheduler #(
        .P          (TP),
        .Q          (TQ),
        .AW         (TAW),
        .WDT_CYCLES (TWDT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .range_err  (range_err),
        .timeout    (timeout),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .coef_in    (coef_in),
        .coef_start (coef_start),
        .coef_done  (coef_done),
        .coef_res   (coef_res),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference state: RAM contents, per-coefficient latency (0 = never answers).
    int  mem[TP];
    int  lat[TP];
    int  exp_data[TP];
    int  exp_rerr[TP];
    int  exp_to[TP];
    int  exp_rerr_end;
    int  exp_to_end;
    int  exp_done;
    int  wr_idx;
    int  lat_idx;
    int  epoch = 0;
    int  stab_err = 0;
    bit  spur_on = 1'b0;
    bit  mon_on = 1'b0;
    bit  rd_pend = 1'b0;
    int  rd_pend_addr = 0;

    task automatic check(input string tag, input logic [31:0] got, input int expv);
        tests++;
        if (got !== 32'(expv)) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    // Input RAM: data valid in the cycle after rd_en, garbage otherwise.
    always @(negedge clk) begin
        rd_pend      = rd_en;
        rd_pend_addr = int'(rd_addr);
    end
    always @(posedge clk) begin
        #1;
        if (rd_pend && rd_pend_addr < TP) rd_data = COEF_W'(mem[rd_pend_addr]);
        else rd_data = COEF_W'($urandom);
    end

    // Mod-3 unit: answers W cycles after its start pulse; checks coef_in is held meanwhile.
    int               dp_w;
    int               dp_ep;
    logic [COEF_W-1:0] dp_c;
    always begin
        @(negedge clk);
        if (coef_start === 1'b1 && !rst) begin
            dp_c  = coef_in;
            dp_ep = epoch;
            dp_w  = (lat_idx < TP) ? lat[lat_idx] : 1;
            lat_idx++;
            if (dp_w > 0) begin
                for (int k = 0; k < dp_w; k++) begin
                    @(posedge clk);
                    #1;
                    if (k == dp_w - 1 && dp_ep == epoch) begin
                        coef_done_m = 1'b1;
                        coef_res    = RES_W'(int'(dp_c) % 3);
                    end
                    @(negedge clk);
                    if (dp_ep == epoch && coef_in !== dp_c) stab_err++;
                end
                @(posedge clk);
                #1;
                coef_done_m = 1'b0;
                coef_res    = RES_W'($urandom);
            end
        end
    end

    // Spurious completions outside WAIT.
    always @(negedge clk) begin
        if (spur_on && (rd_en || coef_start)) begin
            spur = 1'b1;
            @(posedge clk);
            #1;
            spur = 1'b0;
        end
    end

    // Output RAM scoreboard: writes must arrive in index order with the expected data.
    always @(negedge clk) begin
        if (mon_on && !rst && wr_en) begin
            if (wr_idx < TP) begin
                check("wr_addr", 32'(wr_addr), wr_idx);
                check("wr_data", 32'(wr_data), exp_data[wr_idx]);
                check("wr_range_err", 32'(range_err), exp_rerr[wr_idx]);
                check("wr_timeout", 32'(timeout), exp_to[wr_idx]);
            end
            wr_idx++;
        end
    end

    task automatic prep();
        int r, t;
        r = 0;
        t = 0;
        exp_done = 1;
        for (int i = 0; i < TP; i++) begin
            if (mem[i] >= TQ) r = 1;
            if (lat[i] == 0) t = 1;
            exp_rerr[i] = r;
            exp_to[i]   = t;
            exp_data[i] = (lat[i] == 0) ? 0 : mem[i] % 3;
            exp_done   += 4 + ((lat[i] == 0) ? TWDT : lat[i]);
        end
        exp_rerr_end = r;
        exp_to_end   = t;
        wr_idx   = 0;
        lat_idx  = 0;
        stab_err = 0;
        mon_on   = 1'b1;
    endtask

    task automatic run_pass(input string name, input bit hold, input bit spur_en);
        int  got_done;
        bit  busy_bad;
        prep();
        spur_on = spur_en;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 if (!hold) start = 1'b0;
        got_done = -1;
        busy_bad = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check({name, ":range_err_cleared"}, 32'(range_err), 0);
                check({name, ":timeout_cleared"}, 32'(timeout), 0);
            end
            if (busy !== 1'b1) busy_bad = 1'b1;
            if (done === 1'b1) begin
                got_done = n;
                start = 1'b0;
                break;
            end
        end
        check({name, ":done_cycle"}, 32'(got_done), exp_done);
        check({name, ":busy_through_pass"}, 32'(busy_bad), 0);
        check({name, ":write_count"}, 32'(wr_idx), TP);
        check({name, ":range_err_end"}, 32'(range_err), exp_rerr_end);
        check({name, ":timeout_end"}, 32'(timeout), exp_to_end);
        check({name, ":coef_in_stable"}, 32'(stab_err), 0);
        @(negedge clk);
        check({name, ":idle_after"}, {30'd0, busy, done}, 0);
        spur_on = 1'b0;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {3'd0, busy, done, range_err, timeout, rd_en, rd_addr, coef_in,
                     coef_start, wr_en, wr_addr, wr_data}, 0);
    endtask

    initial begin
        int seen;
        rst         = 1'b1;
        start       = 1'b0;
        spur        = 1'b0;
        coef_done_m = 1'b0;
        coef_res    = '0;
        rd_data     = '0;
        repeat (3) @(posedge clk);
        #1 check_all_zero("reset_outputs");
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Basic pass, W=1.
        mem = '{0, 1, 2, 4590};
        lat = '{1, 1, 1, 1};
        run_pass("basic", 1'b0, 1'b0);

        // Variable latency.
        mem = '{100, 4000, 7, 3333};
        lat = '{1, 3, 7, 2};
        run_pass("latency", 1'b0, 1'b0);

        // Out-of-range coefficient at index 2; still processed.
        mem = '{5, 6, 4591, 7};
        lat = '{1, 2, 1, 1};
        run_pass("range", 1'b0, 1'b0);

        // start held high and spurious completions outside WAIT.
        mem = '{9, 10, 11, 12};
        lat = '{2, 1, 4, 1};
        run_pass("ignored_hs", 1'b1, 1'b1);

        // Reset during WAIT of index 1, then a clean pass.
        mem = '{20, 21, 22, 23};
        lat = '{1, 6, 1, 1};
        prep();
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int n = 0; n < 100 && seen < 2; n++) begin
            @(negedge clk);
            if (coef_start === 1'b1) seen++;
        end
        check("midreset:reached_kick1", 32'(seen), 2);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        epoch++;
        #1 check_all_zero("midreset:outputs");
        check("midreset:writes_before", 32'(wr_idx), 1);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (12) @(posedge clk);
        lat = '{1, 2, 1, 3};
        run_pass("after_reset", 1'b0, 1'b0);

`ifdef DECAP_SCHED_WDT_EN
        // Unit never answers on index 0.
        mem = '{30, 31, 32, 33};
        lat = '{0, 2, 1, 3};
        run_pass("watchdog", 1'b0, 1'b0);
`endif

        // Randomized passes.
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < TP; i++) begin
                mem[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TQ, 8191))
                                                     : int'($urandom_range(0, TQ - 1));
                lat[i] = int'($urandom_range(1, 7));
            end
            run_pass($sformatf("rand%0d", r), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decap_mod3_scheduler.md
# decap_mod3_scheduler

Sequences the per-coefficient "center then reduce mod 3" step of decapsulation over a whole polynomial. It walks coefficient indices 0..P-1 and reads each 13-bit coefficient from a synchronous RAM. It hands the coefficient to the existing single-coefficient mod-3 datapath through a start/done handshake, then writes the 2-bit result to an output RAM. It sits between the decap top-level controller (start/busy/done) and the mod-3 datapath plus its two coefficient memories.

## Interface
Parameters:
- P, 761: number of coefficients per pass.
- Q, 4591: modulus; used only for the input range check.
- AW, 10: address width; must satisfy 2^AW >= P.
- WDT_CYCLES, 64: watchdog limit in cycles. Only meaningful with DECAP_SCHED_WDT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a pass. Sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when the pass is complete.
- range_err  out  1  sticky; set if any coefficient read is >= Q. Cleared on accepted start.
- timeout  out  1  sticky watchdog flag. Cleared on accepted start. Constant 0 without the macro.
- rd_en  out  1  read strobe to the input RAM.
- rd_addr  out  AW  read address.
- rd_data  in  13  read data, valid exactly one cycle after rd_en.
- coef_in  out  13  registered coefficient presented to the mod-3 datapath. Stable from KICK through WAIT.
- coef_start  out  1  one-cycle start pulse to the datapath.
- coef_done  in  1  datapath completion.
- coef_res  in  2  datapath result (0..2), valid while coef_done is high.
- wr_en  out  1  write strobe to the output RAM.
- wr_addr  out  AW  write address.
- wr_data  out  2  write data.

## Operation
- FSM states and transitions:
  - IDLE: on start, go to READ; idx=0; clear range_err and timeout.
  - READ: rd_en=1, rd_addr=idx; go to LATCH.
  - LATCH: coef_in<=rd_data. If rd_data>=Q, set range_err; the coefficient is still processed. Go to KICK.
  - KICK: coef_start=1; go to WAIT.
  - WAIT: while coef_done=0, stay. When coef_done=1, res<=coef_res and go to WRITE.
  - WRITE: wr_en=1, wr_addr=idx, wr_data=res. If idx==P-1, go to FIN; else idx<=idx+1 and go to READ.
  - FIN: done=1; go to IDLE.
- busy=1 in every state except IDLE.
- start while busy is ignored; it is neither queued nor restarted.
- coef_done is honoured only in WAIT; any coef_done seen in other states is ignored.
- coef_done in the cycle right after KICK is legal; WAIT then lasts 1 cycle.
- idx is AW bits and never wraps: the pass terminates at P-1.
- Reset values, for any state including mid-pass:
  - FSM=IDLE; idx, coef_in, res = 0.
  - All outputs 0.
  - The output RAM keeps whatever was already written; there is no cleanup.

## Timing
- Per coefficient: READ, LATCH, KICK, W WAIT cycles (W>=1), WRITE, i.e. 4+W cycles.
- Full pass: start sampled at cycle 0, busy high from cycle 1, done at cycle 1+P·(4+W). With W=1: done at cycle 1+5P (3806 for P=761).
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- wr_addr and rd_addr each equal idx during their strobe cycles.

## Configuration
- DECAP_SCHED_WDT_EN defined:
  - A wait counter runs in WAIT. If coef_done has not arrived after WDT_CYCLES WAIT cycles, go to WRITE with wr_data=0 and set timeout.
  - The pass then continues normally with the next coefficient.
- DECAP_SCHED_WDT_EN undefined:
  - WAIT waits indefinitely; the counter is absent and timeout is tied to 0.

## Structure
- Shared package decap_pkg holds:
  - P, Q, coefficient width (13), result width (2);
  - the FSM state enum.
- The decap top-level controller reuses the package constants.
- One natural sub-module: decap_idx_counter. It provides the AW-bit index with clear, increment and a last (idx==P-1) flag.
- The watchdog counter stays inline.

## Test plan
- Basic pass: P=4, RAM={0,1,2,4590}, model unit with W=1 returning x mod 3 -> writes {0,1,2,0} at addresses 0..3; done at cycle 21; busy high for cycles 1..21.
- Variable latency: W = 1, 3, 7 per coefficient -> the done cycle matches 1+Σ(4+W); coef_in stays stable throughout each WAIT.
- Range check: coefficient 4591 at index 2 -> range_err=1 from LATCH onward, result still written, range_err cleared by the next start.
- Ignored handshakes: start held high during the pass, and a spurious coef_done during READ -> no restart and no premature write.
- Reset mid-pass: assert rst during WAIT of index 1 -> all outputs 0 immediately; a new start produces a clean pass from index 0.
- Watchdog (macro on, WDT_CYCLES=8): unit never responds on index 0 -> wr_data=0 at address 0 after 8 WAIT cycles, timeout=1, indices 1..P-1 processed normally.
